// File: rtl/pt_check.sv
// pt_check: scans decrypted plaintext memory (byte 0 = length L, bytes 1..L
// = characters) and reports whether every character lies in the printable
// range [LO_CHAR, HI_CHAR]. On the first out-of-range byte it stops reading
// and reports that byte's index.
module pt_check #(
    parameter int          ADDR_W  = 8,
    parameter logic [7:0]  LO_CHAR = 8'h20,
    parameter logic [7:0]  HI_CHAR = 8'h7E
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] pt_addr,
    input  logic [7:0]        pt_rddata,
    output logic              pt_valid,
    output logic [ADDR_W-1:0] bad_idx,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_SCAN,
        S_FIN
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] len_q, len_nxt;
    logic [ADDR_W-1:0] idx_q, idx_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] bad_nxt;
    logic              valid_nxt;
    logic              char_ok;
    logic [ADDR_W-1:0] len_rd;

    // Printable test on the byte currently returned by memory.
    assign char_ok = (pt_rddata >= LO_CHAR) && (pt_rddata <= HI_CHAR);
    assign len_rd  = ADDR_W'(pt_rddata);

    // rdy and done are decoded straight from the state register.
    assign rdy  = (state == S_IDLE) || (state == S_FIN);
    assign done = (state == S_FIN);

    // Next-state, address sequencing and result computation.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        len_nxt   = len_q;
        idx_nxt   = idx_q;
        addr_nxt  = pt_addr;
        bad_nxt   = bad_idx;
        valid_nxt = pt_valid;

        case (state)
            S_IDLE, S_FIN: begin
                if (en) begin
                    // Accepting a request: fetch the length byte first.
                    state_nxt = S_LEN;
                    addr_nxt  = '0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end

            S_LEN: begin
                len_nxt = len_rd;
                if (len_rd == '0) begin
                    // Empty message is trivially printable.
                    state_nxt = S_FIN;
                    valid_nxt = 1'b1;
                    bad_nxt   = '0;
                end else begin
                    state_nxt = S_SCAN;
                    idx_nxt   = ADDR_W'(1);
                    addr_nxt  = ADDR_W'(1);
                end
            end

            S_SCAN: begin
                if (!char_ok) begin
                    // First bad character ends the scan; no further reads.
                    state_nxt = S_FIN;
                    valid_nxt = 1'b0;
                    bad_nxt   = idx_q;
                end else if (idx_q == len_q) begin
                    // Last character checked; compare before incrementing so
                    // L = all-ones never wraps the address.
                    state_nxt = S_FIN;
                    valid_nxt = 1'b1;
                    bad_nxt   = '0;
                end else begin
                    idx_nxt  = idx_q + ADDR_W'(1);
                    addr_nxt = idx_q + ADDR_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values computed above.
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            pt_addr  <= '0;
            pt_valid <= 1'b0;
            bad_idx  <= '0;
        end else begin
            state    <= state_nxt;
            len_q    <= len_nxt;
            idx_q    <= idx_nxt;
            pt_addr  <= addr_nxt;
            pt_valid <= valid_nxt;
            bad_idx  <= bad_nxt;
        end
    end

endmodule

// File: tb/tb_pt_check.sv
// Directed testbench for pt_check: plaintext memory model, directed scans
// with hand-computed latencies/results, reset abort and back-to-back starts.
module tb_pt_check;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic       pt_valid;
    logic [7:0] bad_idx;
    logic       done;

    logic [7:0] mem [256];

    int compared;
    int mismatched;

    pt_check #(
        .ADDR_W  (8),
        .LO_CHAR (8'h20),
        .HI_CHAR (8'h7E)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .pt_valid  (pt_valid),
        .bad_idx   (bad_idx),
        .done      (done)
    );

    // pt_addr is the memory's address register: the byte it selects is
    // presented in the cycle after the address was computed.
    assign pt_rddata = mem[pt_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Counts negedges after the accepting edge until done (bounded).
    task automatic wait_done(output int cyc, output logic [7:0] max_a);
        bit seen;
        seen  = 0;
        cyc   = 0;
        max_a = 8'h00;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (pt_addr > max_a) max_a = pt_addr;
            if (done === 1'b1) seen = 1;
        end
        if (!seen) cyc = -1;
    endtask

    // Starts one scan from a negedge and checks latency and result.
    task automatic run_scan(input string tag, input int exp_cyc, input logic exp_valid,
                            input logic [7:0] exp_bad, input logic [7:0] exp_max);
        int         cyc;
        logic [7:0] max_a;
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        wait_done(cyc, max_a);
        check({tag, " done_cycle"}, cyc, exp_cyc);
        check({tag, " rdy_at_done"}, rdy, 1'b1);
        check({tag, " pt_valid"}, pt_valid, exp_valid);
        check({tag, " bad_idx"}, bad_idx, exp_bad);
        check({tag, " max_addr"}, max_a, exp_max);
        @(negedge clk);
        check({tag, " done_one_cycle"}, done, 1'b0);
        check({tag, " rdy_idle"}, rdy, 1'b1);
    endtask

    initial begin
        int         cyc;
        logic [7:0] max_a;
        bit         done_seen;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        en         = 1'b0;
        clear_mem();

        repeat (2) @(negedge clk);
        check("reset rdy", rdy, 1'b1);
        check("reset pt_addr", pt_addr, 8'h00);
        check("reset pt_valid", pt_valid, 1'b0);
        check("reset bad_idx", bad_idx, 8'h00);
        check("reset done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Full pass, L=3.
        clear_mem();
        mem[0] = 8'd3; mem[1] = "A"; mem[2] = "b"; mem[3] = "~";
        run_scan("pass3", 5, 1'b1, 8'd0, 8'd3);

        // Fail at index 2 on 0x7F.
        clear_mem();
        mem[0] = 8'd4; mem[1] = "H"; mem[2] = 8'h7F; mem[3] = "i"; mem[4] = "!";
        run_scan("fail7f", 4, 1'b0, 8'd2, 8'd2);

        // Empty message.
        clear_mem();
        mem[0] = 8'd0; mem[1] = 8'h01;
        run_scan("empty", 2, 1'b1, 8'd0, 8'd0);

        // Inclusive boundaries: 0x20 and 0x7E pass, 0x1F fails.
        clear_mem();
        mem[0] = 8'd4; mem[1] = 8'h20; mem[2] = 8'h7E; mem[3] = 8'h1F; mem[4] = 8'h41;
        run_scan("bound1f", 5, 1'b0, 8'd3, 8'd3);

        // 0xFF fails.
        clear_mem();
        mem[0] = 8'd2; mem[1] = "a"; mem[2] = 8'hFF;
        run_scan("failff", 4, 1'b0, 8'd2, 8'd2);

        // 0x00 fails at the first character.
        clear_mem();
        mem[0] = 8'd1; mem[1] = 8'h00;
        run_scan("fail00", 3, 1'b0, 8'd1, 8'd1);

        // Maximum length, no address wrap.
        clear_mem();
        mem[0] = 8'd255;
        for (int i = 1; i < 256; i++) mem[i] = 8'h61;
        run_scan("len255", 257, 1'b1, 8'd0, 8'd255);

        // Ignored en mid-scan, then reset abort.
        clear_mem();
        mem[0] = 8'd3; mem[1] = "A"; mem[2] = "b"; mem[3] = "~";
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        check("abort len_busy", rdy, 1'b0);
        en = 1'b1;
        @(negedge clk);
        check("abort en_ignored_addr", pt_addr, 8'd1);
        check("abort en_ignored_rdy", rdy, 1'b0);
        en  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort rdy", rdy, 1'b1);
        check("abort pt_valid", pt_valid, 1'b0);
        check("abort bad_idx", bad_idx, 8'd0);
        check("abort pt_addr", pt_addr, 8'd0);
        rst = 1'b0;
        done_seen = 0;
        repeat (6) begin
            if (done === 1'b1) done_seen = 1;
            @(negedge clk);
        end
        check("abort no_done", done_seen, 1'b0);

        // Fresh scan after reset.
        clear_mem();
        mem[0] = 8'd4; mem[1] = "H"; mem[2] = 8'h7F; mem[3] = "i"; mem[4] = "!";
        run_scan("after_rst", 4, 1'b0, 8'd2, 8'd2);

        // Back-to-back: en held through FIN starts a second scan at once.
        clear_mem();
        mem[0] = 8'd3; mem[1] = "A"; mem[2] = "b"; mem[3] = "~";
        en = 1'b1;
        @(posedge clk);
        wait_done(cyc, max_a);
        check("b2b first_cycle", cyc, 5);
        check("b2b first_valid", pt_valid, 1'b1);
        mem[0] = 8'd2; mem[1] = "x"; mem[2] = 8'h05;
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        check("b2b second_accepted", rdy, 1'b0);
        check("b2b second_addr", pt_addr, 8'd0);
        wait_done(cyc, max_a);
        check("b2b second_cycle", cyc, 3);
        check("b2b second_valid", pt_valid, 1'b0);
        check("b2b second_bad", bad_idx, 8'd2);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
